// File: rtl/aes_kat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_kat_pkg
// Description : Shared state encoding, FIPS-197 vectors and widths for the
//               AES known-answer-test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_kat_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_ENC_WAIT = 3'd2,
        S_DEC_WAIT = 3'd3,
        S_NEXT     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int CNT_W     = 3;
    localparam int MASK_W    = 4;
    localparam int IDX_W     = 2;
    localparam int KEY_MAX_W = 256;

    // Every v0 key is a leading slice of this byte sequence.
    localparam logic [KEY_MAX_W-1:0] C_KEY_SEQ =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C_KEY128_V1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    localparam logic [127:0] C_PT_V0     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_PT_V1     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_CT128_V0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_CT128_V1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_CT192_V0  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C_CT256_V0  = 128'h8ea2b7ca516745bfeafc49904b496089;

    function automatic int num_vec(input int nk);
        return (nk == 4) ? 2 : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_kat_rom.sv
`default_nettype none
// ============================================================================
// Module      : aes_kat_rom
// Description : Combinational (Nk, idx) -> {key, pt, ct} vector lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_kat_rom
    import aes_kat_pkg::*;
#(
    parameter int Nk = 4
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [Nk*32-1:0]   key,
    output logic [127:0]       pt,
    output logic [127:0]       ct
);

    localparam int KEY_W = Nk * 32;

    always_comb begin
        key = KEY_W'(C_KEY_SEQ >> (KEY_MAX_W - KEY_W));
        pt  = C_PT_V0;
        ct  = C_CT128_V0;
        if (Nk == 8) begin
            ct = C_CT256_V0;
        end else if (Nk == 6) begin
            ct = C_CT192_V0;
        end else if (idx == IDX_W'(1)) begin
            key = KEY_W'(C_KEY128_V1);
            pt  = C_PT_V1;
            ct  = C_CT128_V1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_kat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_kat_sequencer
// Description : Runs every FIPS-197 vector of the configured key size through
//               the AES datapath (encrypt then decrypt) and scores the results.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_kat_sequencer
    import aes_kat_pkg::*;
#(
    parameter int Nk      = 4,
    parameter int Nr      = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                done_out_Enc,
    input  logic                done_out_Dec,
    input  logic [127:0]        data_out,
    output logic                core_reset,
    output logic [127:0]        data_in,
    output logic [Nk*32-1:0]    key_in,
    output logic                busy,
    output logic                run_done,
    output logic [CNT_W-1:0]    pass_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic [MASK_W-1:0]   fail_mask,
    output logic                timeout_flag
);

    localparam int                NUM_VEC    = num_vec(Nk);
    localparam int                TMR_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  C_TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(NUM_VEC - 1);

    // Nr configures only the external datapath.
    if (Nr > 0) begin : g_nr_passthrough
    end

    state_t              r_state, w_state_next;
    logic [IDX_W-1:0]    r_idx, w_idx_next;
    logic [TMR_W-1:0]    r_timer, w_timer_next;
    logic                r_enc_ok, w_enc_ok_next;
    logic                r_dec_ok, w_dec_ok_next;
    logic [127:0]        w_data_in_next;
    logic [Nk*32-1:0]    w_key_in_next;
    logic                w_core_reset_next, w_busy_next, w_run_done_next;
    logic [CNT_W-1:0]    w_pass_next, w_fail_next;
    logic [MASK_W-1:0]   w_mask_next;
    logic                w_tflag_next;
    logic                w_timer_last;
    logic [Nk*32-1:0]    w_rom_key;
    logic [127:0]        w_rom_pt, w_rom_ct;

    aes_kat_rom #(.Nk(Nk)) u_rom (
        .idx (r_idx),
        .key (w_rom_key),
        .pt  (w_rom_pt),
        .ct  (w_rom_ct)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_timer      <= '0;
            r_enc_ok     <= 1'b0;
            r_dec_ok     <= 1'b0;
            core_reset   <= 1'b1;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            data_in      <= C_PT_V0;
            key_in       <= C_KEY_SEQ[KEY_MAX_W-1 -: Nk*32];
            pass_count   <= '0;
            fail_count   <= '0;
            fail_mask    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_timer      <= w_timer_next;
            r_enc_ok     <= w_enc_ok_next;
            r_dec_ok     <= w_dec_ok_next;
            core_reset   <= w_core_reset_next;
            busy         <= w_busy_next;
            run_done     <= w_run_done_next;
            data_in      <= w_data_in_next;
            key_in       <= w_key_in_next;
            pass_count   <= w_pass_next;
            fail_count   <= w_fail_next;
            fail_mask    <= w_mask_next;
            timeout_flag <= w_tflag_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_timer_next   = r_timer;
        w_enc_ok_next  = r_enc_ok;
        w_dec_ok_next  = r_dec_ok;
        w_data_in_next = data_in;
        w_key_in_next  = key_in;
        w_pass_next    = pass_count;
        w_fail_next    = fail_count;
        w_mask_next    = fail_mask;
        w_tflag_next   = timeout_flag;
        w_timer_last   = (r_timer == C_TMR_LAST);

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_idx_next   = '0;
                    w_pass_next  = '0;
                    w_fail_next  = '0;
                    w_mask_next  = '0;
                    w_tflag_next = 1'b0;
                end
            end
            S_LOAD: begin
                w_data_in_next = w_rom_pt;
                w_key_in_next  = w_rom_key;
                w_timer_next   = '0;
                w_enc_ok_next  = 1'b0;
                w_dec_ok_next  = 1'b0;
                w_state_next   = S_ENC_WAIT;
            end
            // A done strobe on the last timer cycle still counts.
            S_ENC_WAIT: begin
                if (done_out_Enc) begin
                    w_enc_ok_next  = (data_out == w_rom_ct);
                    w_data_in_next = w_rom_ct;
                    w_timer_next   = '0;
                    w_state_next   = S_DEC_WAIT;
                end else if (w_timer_last) begin
                    w_tflag_next = 1'b1;
                    w_state_next = S_NEXT;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_DEC_WAIT: begin
                if (done_out_Dec) begin
                    w_dec_ok_next = (data_out == w_rom_pt);
                    w_state_next  = S_NEXT;
                end else if (w_timer_last) begin
                    w_tflag_next = 1'b1;
                    w_state_next = S_NEXT;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_NEXT: begin
                if (r_enc_ok && r_dec_ok) begin
                    w_pass_next = pass_count + 1'b1;
                end else begin
                    w_fail_next        = fail_count + 1'b1;
                    w_mask_next[r_idx] = 1'b1;
                end
                if (r_idx == C_IDX_LAST) begin
                    w_state_next = S_DONE;
                end else begin
                    w_idx_next   = r_idx + 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        w_core_reset_next = !((w_state_next == S_ENC_WAIT) || (w_state_next == S_DEC_WAIT));
        w_busy_next       = (w_state_next == S_LOAD) || (w_state_next == S_ENC_WAIT) ||
                            (w_state_next == S_DEC_WAIT) || (w_state_next == S_NEXT);
        w_run_done_next   = (w_state_next == S_DONE);
    end

endmodule
`default_nettype wire

// File: doc/aes_kat_sequencer.md
# aes_kat_sequencer

Known-answer-test sequencer that sits directly upstream of the SPI_Master-based AES datapath and drives its `data_in`/`key_in`. It also consumes `data_out` and the encrypt/decrypt done strobes. For each FIPS-197 vector of the configured key size, it restarts the datapath and applies the plaintext. On encrypt-done it swaps in the ciphertext, then checks both results. It accumulates pass/fail counts and per-phase timeouts, and replaces hard-wired single-vector checking with a restartable multi-vector run.

## Interface
- `Nk`, 4: key length in 32-bit words (4/6/8).
- `Nr`, 10: round count; passed through to the datapath instance, unused internally.
- `TIMEOUT`, 4096: maximum cycles allowed per phase (encrypt or decrypt) before the vector is failed.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level, sampled only in IDLE/DONE; begins a run.
- `done_out_Enc` in 1: datapath encrypt complete, `data_out` valid.
- `done_out_Dec` in 1: datapath decrypt complete, `data_out` valid.
- `data_out` in 128: datapath result.
- `core_reset` out 1: synchronous reset to the datapath; high holds it idle.
- `data_in` out 128: block fed to the datapath.
- `key_in` out Nk*32: key fed to the datapath.
- `busy` out 1: run in progress.
- `run_done` out 1: run finished; held until the next start.
- `pass_count` out 3: vectors passed this run.
- `fail_count` out 3: vectors failed this run.
- `fail_mask` out 4: bit i set means vector i failed.
- `timeout_flag` out 1: sticky per run; any phase timed out.

## Operation
- Vector table per Nk; NUM_VEC = 2 for Nk=4, 1 otherwise.
  - Nk=4 v0: key 000102…0f, pt 00112233445566778899aabbccddeeff, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Nk=4 v1: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, ct 3925841d02dc09fbdc118597196a0b32.
  - Nk=6 v0: key 000102…17, same pt, ct dda97ca4864cdfe06eaf70a0ec0d7191.
  - Nk=8 v0: key 000102…1f, same pt, ct 8ea2b7ca516745bfeafc49904b496089.
- FSM states: IDLE, LOAD, ENC_WAIT, DEC_WAIT, NEXT, DONE.
  - IDLE/DONE + start: go to LOAD. Clear counts, fail_mask, timeout_flag and idx. DONE drops run_done.
  - LOAD: data_in←pt[idx], key_in←key[idx], timer←0, enc_ok/dec_ok←0. Go to ENC_WAIT.
  - ENC_WAIT + done_out_Enc: enc_ok←(data_out==ct[idx]), data_in←ct[idx], timer←0. Go to DEC_WAIT.
  - DEC_WAIT + done_out_Dec: dec_ok←(data_out==pt[idx]). Go to NEXT.
  - ENC_WAIT/DEC_WAIT with timer==TIMEOUT-1 and no matching done: vector fails, timeout_flag←1. Go to NEXT; an encrypt timeout skips decrypt.
  - NEXT: if enc_ok&&dec_ok, pass_count+1; else fail_count+1 and fail_mask[idx]←1. If idx==NUM_VEC-1, go to DONE; else idx+1 and go to LOAD.
- `core_reset` is 1 in IDLE, LOAD, NEXT and DONE, and 0 in ENC_WAIT and DEC_WAIT.
- `busy` is 1 in LOAD through NEXT.
- Done strobes are ignored outside their own wait state; done_out_Dec in ENC_WAIT is ignored.
- Done and timeout in the same cycle: done wins.
- start while busy: ignored.
- Mid-run reset: returns to IDLE immediately with all reset values; partial results are discarded.
- Reset values: state IDLE, core_reset 1, busy 0, run_done 0, counts 0, fail_mask 0, timeout_flag 0, data_in = pt v0, key_in = key v0.

## Timing
- All outputs are registered.
- start sampled at edge t: LOAD during t+1, core_reset falls at t+2 (ENC_WAIT).
- done_out_Enc sampled at edge e: data_in = ct and DEC_WAIT from e+1; core_reset stays low.
- done_out_Dec sampled at edge d: NEXT at d+1, counts updated at d+2.
- run_done rises 1 cycle after the last NEXT.
- Timer width is clog2(TIMEOUT). A timeout fires on the TIMEOUT-th cycle in the wait state.
- Per-vector overhead beyond datapath latency: 3 cycles (LOAD, NEXT, plus the phase-switch cycle).

## Structure
- Shared package `aes_kat_pkg`: state encoding, vector constants, NUM_VEC as a function of Nk, count widths.
- Sub-module `aes_kat_rom`: combinational lookup (Nk, idx) → {key, pt, ct}.
- The FSM, timer and scoreboard stay in `aes_kat_sequencer`.

## Test plan
- Nk=4, behavioural datapath model returning correct results: start → pass_count=2, fail_count=0, fail_mask=0, run_done=1.
- Nk=4, model corrupts v1 ciphertext: pass_count=1, fail_count=1, fail_mask=4'b0010, timeout_flag=0.
- Nk=6, model never asserts done_out_Enc, TIMEOUT=16: after 16 cycles in ENC_WAIT, fail_count=1, timeout_flag=1, no DEC_WAIT entered.
- Nk=8, done_out_Enc and timeout in the same cycle with a correct result: vector passes (pass_count=1).
- Mid-run reset during DEC_WAIT, then start: all outputs return to reset values, data_in=00112233…eeff, full rerun passes.
- start held high continuously plus spurious done_out_Dec in ENC_WAIT: no re-launch while busy, spurious strobe ignored, results match the clean run.
